// File: rtl/gf2_pkg.sv
// Shared GF(2) arithmetic definitions: default operand widths and the
// divider's state encoding.
package gf2_pkg;

   localparam int GF2_M = 4;
   localparam int GF2_N = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gf2_poly_div_if.sv
// Request/response bundle for the GF(2) polynomial divider.
interface gf2_poly_div_if #(
   parameter int M = 4,
   parameter int N = 7
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [M-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [M-2:0] remainder;
   logic         div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/gf2_msb_index.sv
// Combinational priority encoder: index of the highest set bit, plus a flag
// for an all-zero input.
module gf2_msb_index #(
   parameter int W  = 4,
   parameter int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  value,
   output logic [IW-1:0] index,
   output logic          zero
);

   // Later (higher) set bits overwrite earlier ones, so the MSB wins.
   always_comb begin
      index = '0;
      zero  = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (value[i]) begin
            index = IW'(i);
            zero  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/gf2_poly_div.sv
// Bit-serial carry-less polynomial long division: one dividend position per
// clock, XOR as subtraction, quotient/remainder held until accepted.
module gf2_poly_div
   import gf2_pkg::*;
#(
   parameter int M = GF2_M,
   parameter int N = GF2_N
) (
   input logic          clk,
   input logic          rst,
   gf2_poly_div_if.slave bus
);

   localparam int DW = (M > 1) ? $clog2(M) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t          state;
   state_t          state_nx;
   logic [M-1:0]    div_r;
   logic [N-1:0]    rem_r;
   logic [N-1:0]    q_r;
   logic [DW-1:0]   d_r;
   logic [CW-1:0]   cnt;
   logic            dbz_r;

   logic [DW-1:0]   d_in;
   logic            div_zero;
   logic            accept;
   logic [CW-1:0]   d_ext;
   logic [CW-1:0]   shift;
   logic            step_hit;
   logic [N-1:0]    div_shifted;
   logic [N-1:0]    q_bit;

   gf2_msb_index #(.W(M), .IW(DW)) u_msb (
      .value (bus.divisor),
      .index (d_in),
      .zero  (div_zero)
   );

   assign accept      = (state == IDLE) && bus.in_valid;
   assign d_ext       = CW'(d_r);
   assign shift       = cnt - d_ext;
   assign step_hit    = (cnt >= d_ext) && rem_r[cnt];
   assign div_shifted = N'(div_r) << shift;
   assign q_bit       = N'(1) << shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nx = RUN;
         RUN:     if (cnt == '0)     state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A zero divisor still spends one RUN cycle (cnt starts at 0 and the
   // cleared remainder never matches), so its result appears one edge after
   // accept instead of N.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_r <= '0;
         rem_r <= '0;
         q_r   <= '0;
         d_r   <= '0;
         cnt   <= '0;
         dbz_r <= 1'b0;
      end else if (accept) begin
         div_r <= bus.divisor;
         d_r   <= d_in;
         q_r   <= '0;
         if (div_zero) begin
            rem_r <= '0;
            cnt   <= '0;
            dbz_r <= 1'b1;
         end else begin
            rem_r <= bus.dividend;
            cnt   <= CW'(N - 1);
            dbz_r <= 1'b0;
         end
      end else if (state == RUN) begin
         if (step_hit) begin
            rem_r <= rem_r ^ div_shifted;
            q_r   <= q_r | q_bit;
         end
         if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Every position at or above the divisor degree must have been cancelled.
   always_ff @(posedge clk) begin
      if (!rst && state == DONE) begin
         assert ((rem_r >> d_r) == '0);
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.quotient    = q_r;
   assign bus.remainder   = rem_r[M-2:0];
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_gf2_poly_div.sv
// Self-checking bench for gf2_poly_div: directed vectors, backpressure,
// reset mid-job, and random pairs checked against a carry-less multiply.
module tb_gf2_poly_div;
   import gf2_pkg::*;

   localparam int M       = GF2_M;
   localparam int N       = GF2_N;
   localparam int P       = N + M - 1;
   localparam int TIMEOUT = 4 * N + 20;

   typedef struct {
      logic [N-1:0] dividend;
      logic [M-1:0] divisor;
      logic         exact;
      logic [N-1:0] q;
      logic [M-2:0] r;
      logic         dbz;
   } sb_t;

   typedef struct {
      logic [N-1:0] dividend;
      logic [M-1:0] divisor;
      logic [N-1:0] q;
      logic [M-2:0] r;
      logic         dbz;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   gf2_poly_div_if #(.M(M), .N(N)) bus ();

   gf2_poly_div #(.M(M), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sb_t  sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [P-1:0] clmul(input logic [N-1:0] a, input logic [M-1:0] b);
      logic [P-1:0] p;
      p = '0;
      for (int j = 0; j < M; j++) begin
         if (b[j]) p = p ^ (P'(a) << j);
      end
      return p;
   endfunction

   function automatic int degree(input logic [M-1:0] b);
      int dg;
      dg = -1;
      for (int j = 0; j < M; j++) begin
         if (b[j]) dg = j;
      end
      return dg;
   endfunction

   // Drives one job, waits for the accept edge and records what to expect.
   task automatic applyStimulus(input logic [N-1:0] dvd, input logic [M-1:0] dvs,
                                input logic exact, input logic [N-1:0] eq,
                                input logic [M-2:0] er, input logic edbz);
      sb_t e;
      int  k;
      @(negedge clk);
      bus.dividend = dvd;
      bus.divisor  = dvs;
      bus.in_valid = 1'b1;
      k = 0;
      while (!bus.in_ready && k < TIMEOUT) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      e.dividend = dvd;
      e.divisor  = dvs;
      e.exact    = exact;
      e.q        = eq;
      e.r        = er;
      e.dbz      = edbz;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = ~dvd;
      bus.divisor  = ~dvs;
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
   endtask

   // Waits for the result, compares it, optionally stalls, then accepts it.
   task automatic checkOutput(input int hold);
      sb_t          e;
      int           lat;
      int           dg;
      logic [N-1:0] q_hold;
      logic [M-2:0] r_hold;
      logic         z_hold;
      logic         stable;
      lat = 0;
      while (!bus.out_valid && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("out_valid", 32'(bus.out_valid), 32'd1);
      if (sb_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check("latency", lat, (e.divisor == '0) ? 32'd1 : 32'(N));
      if (e.exact) begin
         check("quotient", 32'(bus.quotient), 32'(e.q));
         check("remainder", 32'(bus.remainder), 32'(e.r));
         check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
      end
      if (e.divisor == '0) begin
         check("dbz_flag", 32'(bus.div_by_zero), 32'd1);
         check("dbz_quotient", 32'(bus.quotient), 32'd0);
         check("dbz_remainder", 32'(bus.remainder), 32'd0);
      end else begin
         dg = degree(e.divisor);
         check("nz_flag", 32'(bus.div_by_zero), 32'd0);
         check("q_times_d_xor_r", 32'(clmul(bus.quotient, e.divisor) ^ P'(bus.remainder)),
               32'(e.dividend));
         check("rem_degree", 32'(bus.remainder) >> dg, 32'd0);
      end
      q_hold = bus.quotient;
      r_hold = bus.remainder;
      z_hold = bus.div_by_zero;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         stable = bus.out_valid && !bus.in_ready && bus.quotient == q_hold &&
                  bus.remainder == r_hold && bus.div_by_zero == z_hold;
         check("hold_stable", 32'(stable), 32'd1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
      check("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      vecs[0] = '{7'b1011010, 4'b1011, 7'b0001000, 3'b010, 1'b0};
      vecs[1] = '{7'b1001011, 4'b1101, 7'b0001111, 3'b000, 1'b0};
      vecs[2] = '{7'b0000111, 4'b0011, 7'b0000010, 3'b001, 1'b0};
      vecs[3] = '{7'b1100101, 4'b0001, 7'b1100101, 3'b000, 1'b0};
      vecs[4] = '{7'b1011101, 4'b0000, 7'b0000000, 3'b000, 1'b1};
      vecs[5] = '{7'b0000000, 4'b1011, 7'b0000000, 3'b000, 1'b0};
      vecs[6] = '{7'b0000101, 4'b1000, 7'b0000000, 3'b101, 1'b0};
      vecs[7] = '{7'b1111111, 4'b0010, 7'b0111111, 3'b001, 1'b0};
      vecs[8] = '{7'b1111111, 4'b1111, 7'b0001000, 3'b111, 1'b0};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      rst = 1'b1;
      #1;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_quotient", 32'(bus.quotient), 32'd0);
      check("reset_remainder", 32'(bus.remainder), 32'd0);
      check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].dividend, vecs[v].divisor, 1'b1,
                       vecs[v].q, vecs[v].r, vecs[v].dbz);
         checkOutput((v == 0 || v == 4) ? 5 : 0);
      end

      // Reset at the third RUN cycle discards the job entirely.
      applyStimulus(7'b1011010, 4'b1011, 1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_run_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_run_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      void'(sb_q.pop_back());
      repeat (N + 2) @(negedge clk);
      check("rst_run_no_result", 32'(bus.out_valid), 32'd0);
      applyStimulus(vecs[1].dividend, vecs[1].divisor, 1'b1, vecs[1].q, vecs[1].r, vecs[1].dbz);
      checkOutput(0);

      // Reset while a result is waiting in DONE.
      applyStimulus(vecs[2].dividend, vecs[2].divisor, 1'b0, '0, '0, 1'b0);
      repeat (N + 1) @(negedge clk);
      check("pre_rst_done_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_done_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_done_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      void'(sb_q.pop_back());
      applyStimulus(vecs[0].dividend, vecs[0].divisor, 1'b1, vecs[0].q, vecs[0].r, vecs[0].dbz);
      checkOutput(0);

      for (int n = 0; n < 2000; n++) begin
         applyStimulus(N'($urandom), M'($urandom_range(0, (1 << M) - 1)), 1'b0, '0, '0, 1'b0);
         checkOutput((n % 97 == 0) ? 2 : 0);
      end

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
